// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline boundary registers: NOP encoding, flush
// opcodes, control-bundle field layout and the slot load/hold select.
package pipe_pkg;

    localparam int          NOP_INSTR_W = 16;
    localparam logic [15:0] NOP_INSTR   = 16'h0800;

    // Opcode field of the 16-bit instruction word.
    localparam int         OPCODE_LSB = 11;
    localparam int         OPCODE_W   = 5;
    localparam logic [4:0] OP_SIIC    = 5'b00010;
    localparam logic [4:0] OP_RTI     = 5'b00011;

    // Control-bundle layout; every stage packs and unpacks with these offsets.
    localparam int CTRL_BASE_W      = 16;
    localparam int CTRL_ALU_OP_LSB  = 0;
    localparam int CTRL_ALU_OP_W    = 4;
    localparam int CTRL_DEST_LSB    = 4;
    localparam int CTRL_DEST_W      = 2;
    localparam int CTRL_REG_WE_BIT  = 6;
    localparam int CTRL_MEM_WE_BIT  = 7;
    localparam int CTRL_MEM_RE_BIT  = 8;
    localparam int CTRL_HALT_BIT    = 9;
    localparam int CTRL_LINK_BIT    = 10;

    localparam logic [CTRL_BASE_W-1:0] CTRL_SIDE_EFFECT_MASK =
        (CTRL_BASE_W'(1) << CTRL_REG_WE_BIT) |
        (CTRL_BASE_W'(1) << CTRL_MEM_WE_BIT) |
        (CTRL_BASE_W'(1) << CTRL_HALT_BIT);

    typedef enum logic [1:0] {
        SLOT_HOLD = 2'd0,
        SLOT_LOAD = 2'd1,
        SLOT_NOP  = 2'd2
    } slot_op_e;

    function automatic logic is_flush_opcode(input logic [OPCODE_W-1:0] op);
        return (op == OP_SIIC) || (op == OP_RTI);
    endfunction

    function automatic logic ctrl_has_side_effect(input logic [CTRL_BASE_W-1:0] c);
        return |(c & CTRL_SIDE_EFFECT_MASK);
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One instruction slot: instruction, control, payload and valid flag, with a
// load / hold / NOP-load select. A NOP load keeps the payload unchanged.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int                  INSTR_W    = 16,
    parameter int                  CTRL_W     = 16,
    parameter int                  DATA_W     = 64,
    parameter logic [INSTR_W-1:0]  NOP_WORD   = INSTR_W'(NOP_INSTR),
    parameter logic [CTRL_W-1:0]   NOP_BUNDLE = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  slot_op_e           op,
    input  logic [INSTR_W-1:0] ld_instr,
    input  logic [CTRL_W-1:0]  ld_ctrl,
    input  logic [DATA_W-1:0]  ld_data,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [CTRL_W-1:0]  ctrl,
    output logic [DATA_W-1:0]  data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            instr <= NOP_WORD;
            ctrl  <= NOP_BUNDLE;
            data  <= '0;
        end else begin
            case (op)
                SLOT_LOAD: begin
                    valid <= 1'b1;
                    instr <= ld_instr;
                    ctrl  <= ld_ctrl;
                    data  <= ld_data;
                end
                SLOT_NOP: begin
                    valid <= 1'b0;
                    instr <= NOP_WORD;
                    ctrl  <= NOP_BUNDLE;
                end
                default: begin
                    valid <= valid;
                    instr <= instr;
                    ctrl  <= ctrl;
                    data  <= data;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register with valid/ready handshake, bubble and flush.
// Define PIPE_SKID_EN to add one skid entry and register the in_ready path.
module pipe_stage_reg #(
    parameter int                 INSTR_W   = 16,
    parameter int                 CTRL_W    = 16,
    parameter int                 DATA_W    = 64,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(pipe_pkg::NOP_INSTR),
    parameter logic [CTRL_W-1:0]  NOP_CTRL  = {CTRL_W{1'b0}}
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [CTRL_W-1:0]  in_ctrl,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               bubble,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [CTRL_W-1:0]  out_ctrl,
    output logic [DATA_W-1:0]  out_data
);

    import pipe_pkg::*;

    logic               advance;
    logic               accept;
    slot_op_e           out_op;
    logic [INSTR_W-1:0] out_src_instr;
    logic [CTRL_W-1:0]  out_src_ctrl;
    logic [DATA_W-1:0]  out_src_data;

    assign advance = ~out_valid | out_ready;
    assign accept  = in_valid & in_ready;

`ifdef PIPE_SKID_EN
    logic               skid_valid;
    logic [INSTR_W-1:0] skid_instr;
    logic [CTRL_W-1:0]  skid_ctrl;
    logic [DATA_W-1:0]  skid_data;
    slot_op_e           skid_op;

    // in_ready only looks at registered skid occupancy, never at out_ready.
    assign in_ready = ~skid_valid & ~bubble & ~flush & ~rst;

    // The skid entry always reaches the output before any newer instruction;
    // a bubble sends a NOP and leaves a waiting skid entry where it is.
    always_comb begin
        out_op        = SLOT_HOLD;
        skid_op       = SLOT_HOLD;
        out_src_instr = in_instr;
        out_src_ctrl  = in_ctrl;
        out_src_data  = in_data;
        if (flush) begin
            out_op  = SLOT_NOP;
            skid_op = SLOT_NOP;
        end else if (advance) begin
            if (bubble) begin
                out_op = SLOT_NOP;
            end else if (skid_valid) begin
                out_op        = SLOT_LOAD;
                out_src_instr = skid_instr;
                out_src_ctrl  = skid_ctrl;
                out_src_data  = skid_data;
                skid_op       = accept ? SLOT_LOAD : SLOT_NOP;
            end else if (accept) begin
                out_op = SLOT_LOAD;
            end else begin
                out_op = SLOT_NOP;
            end
        end else if (accept) begin
            skid_op = SLOT_LOAD;
        end
    end

    pipe_slot #(
        .INSTR_W    (INSTR_W),
        .CTRL_W     (CTRL_W),
        .DATA_W     (DATA_W),
        .NOP_WORD   (NOP_INSTR),
        .NOP_BUNDLE (NOP_CTRL)
    ) u_skid_slot (
        .clk      (clk),
        .rst      (rst),
        .op       (skid_op),
        .ld_instr (in_instr),
        .ld_ctrl  (in_ctrl),
        .ld_data  (in_data),
        .valid    (skid_valid),
        .instr    (skid_instr),
        .ctrl     (skid_ctrl),
        .data     (skid_data)
    );
`else
    assign in_ready = advance & ~bubble & ~flush & ~rst;

    // A stalled output (valid, not consumed) holds; otherwise it takes the
    // accepted instruction or falls back to a NOP.
    always_comb begin
        out_op        = SLOT_HOLD;
        out_src_instr = in_instr;
        out_src_ctrl  = in_ctrl;
        out_src_data  = in_data;
        if (flush) begin
            out_op = SLOT_NOP;
        end else if (advance) begin
            out_op = accept ? SLOT_LOAD : SLOT_NOP;
        end
    end
`endif

    pipe_slot #(
        .INSTR_W    (INSTR_W),
        .CTRL_W     (CTRL_W),
        .DATA_W     (DATA_W),
        .NOP_WORD   (NOP_INSTR),
        .NOP_BUNDLE (NOP_CTRL)
    ) u_out_slot (
        .clk      (clk),
        .rst      (rst),
        .op       (out_op),
        .ld_instr (out_src_instr),
        .ld_ctrl  (out_src_ctrl),
        .ld_data  (out_src_data),
        .valid    (out_valid),
        .instr    (out_instr),
        .ctrl     (out_ctrl),
        .data     (out_data)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vectors on a default-width instance with a
// queue-based reference model, plus a randomized stream on a wide instance.
module tb_pipe_stage_reg;

    localparam logic [15:0] SIDE_MASK = 16'h02C0;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] ctrl;
        logic [63:0] data;
    } nitem_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [23:0] ctrl;
        logic [95:0] data;
    } witem_t;

    logic clk;
    logic rst;

    logic        n_in_valid, n_in_ready, n_bubble, n_flush, n_out_valid, n_out_ready;
    logic [15:0] n_in_instr, n_in_ctrl, n_out_instr, n_out_ctrl;
    logic [63:0] n_in_data, n_out_data;

    logic        w_in_valid, w_in_ready, w_bubble, w_flush, w_out_valid, w_out_ready;
    logic [31:0] w_in_instr, w_out_instr;
    logic [23:0] w_in_ctrl, w_out_ctrl;
    logic [95:0] w_in_data, w_out_data;

    int total = 0;
    int bad   = 0;

    pipe_stage_reg u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (n_in_valid),
        .in_ready  (n_in_ready),
        .in_instr  (n_in_instr),
        .in_ctrl   (n_in_ctrl),
        .in_data   (n_in_data),
        .bubble    (n_bubble),
        .flush     (n_flush),
        .out_valid (n_out_valid),
        .out_ready (n_out_ready),
        .out_instr (n_out_instr),
        .out_ctrl  (n_out_ctrl),
        .out_data  (n_out_data)
    );

    pipe_stage_reg #(
        .INSTR_W (32),
        .CTRL_W  (24),
        .DATA_W  (96)
    ) u_dut_wide (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (w_in_valid),
        .in_ready  (w_in_ready),
        .in_instr  (w_in_instr),
        .in_ctrl   (w_in_ctrl),
        .in_data   (w_in_data),
        .bubble    (w_bubble),
        .flush     (w_flush),
        .out_valid (w_out_valid),
        .out_ready (w_out_ready),
        .out_instr (w_out_instr),
        .out_ctrl  (w_out_ctrl),
        .out_data  (w_out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model for the default instance ----------------
    // Holds what the stage presents plus the instructions it has taken but not
    // yet presented; rules are applied once per cycle from the driven inputs.
    logic        m_init = 1'b0;
    logic        m_valid;
    logic [15:0] m_instr, m_ctrl;
    logic [63:0] m_data;
    nitem_t      m_pending[$];

    function automatic logic model_ready();
        if (rst || n_flush || n_bubble) return 1'b0;
`ifdef PIPE_SKID_EN
        return m_pending.size() == 0;
`else
        return !m_valid || n_out_ready;
`endif
    endfunction

    task automatic model_present_nop();
        m_valid = 1'b0;
        m_instr = 16'h0800;
        m_ctrl  = 16'h0000;
    endtask

    always @(negedge clk) begin
        logic   acc, used;
        nitem_t it;
        if (m_init) begin
            check("in_ready", {127'b0, n_in_ready}, {127'b0, model_ready()});
            check("out_valid", {127'b0, n_out_valid}, {127'b0, m_valid});
            check("out_instr", {112'b0, n_out_instr}, {112'b0, m_instr});
            check("out_ctrl", {112'b0, n_out_ctrl}, {112'b0, m_ctrl});
            check("out_data", {64'b0, n_out_data}, {64'b0, m_data});
        end
        acc  = n_in_valid && model_ready();
        used = 1'b0;
        if (rst) begin
            model_present_nop();
            m_data = '0;
            m_pending.delete();
            m_init = 1'b1;
        end else if (n_flush) begin
            model_present_nop();
            m_pending.delete();
        end else if (!m_valid || n_out_ready) begin
            if (n_bubble) begin
                model_present_nop();
            end else if (m_pending.size() > 0) begin
                it      = m_pending.pop_front();
                m_valid = 1'b1;
                m_instr = it.instr;
                m_ctrl  = it.ctrl;
                m_data  = it.data;
            end else if (acc) begin
                m_valid = 1'b1;
                m_instr = n_in_instr;
                m_ctrl  = n_in_ctrl;
                m_data  = n_in_data;
                used    = 1'b1;
            end else begin
                model_present_nop();
            end
        end
        if (!rst && !n_flush && acc && !used)
            m_pending.push_back('{n_in_instr, n_in_ctrl, n_in_data});
    end

    // ---------------- scoreboard for the wide instance ----------------
    logic   wide_run = 1'b0;
    witem_t w_sent[$];
    int     w_sent_cnt = 0;
    int     w_recv_cnt = 0;

    always @(negedge clk) begin
        witem_t it;
        if (wide_run && !rst) begin
            if (w_out_valid && w_out_ready) begin
                if (w_sent.size() == 0) begin
                    check("wide_spurious", 128'd1, 128'd0);
                end else begin
                    it = w_sent.pop_front();
                    check("wide_instr", {96'b0, w_out_instr}, {96'b0, it.instr});
                    check("wide_ctrl", {104'b0, w_out_ctrl}, {104'b0, it.ctrl});
                    check("wide_data", {32'b0, w_out_data}, {32'b0, it.data});
                    w_recv_cnt++;
                end
            end
            if (!w_out_valid) begin
                check("wide_nop_side", {112'b0, w_out_ctrl[15:0] & SIDE_MASK}, 128'd0);
                check("wide_nop_instr", {96'b0, w_out_instr}, 128'h0800);
            end
            if (w_in_valid && w_in_ready) begin
                w_sent.push_back('{w_in_instr, w_in_ctrl, w_in_data});
                w_sent_cnt++;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic applyStimulus(input logic v, input logic [15:0] instr, input logic ordy,
                                 input logic bub, input logic fl);
        n_in_valid  = v;
        n_in_instr  = instr;
        n_in_ctrl   = instr ^ 16'hA5A5;
        n_in_data   = {4{instr}};
        n_out_ready = ordy;
        n_bubble    = bub;
        n_flush     = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkReady(input string name, input logic exp);
        check(name, {127'b0, n_in_ready}, {127'b0, exp});
    endtask

    task automatic checkOutput(input string name, input logic exp_valid,
                               input logic [15:0] exp_instr, input logic [15:0] exp_ctrl);
        check({name, ".valid"}, {127'b0, n_out_valid}, {127'b0, exp_valid});
        check({name, ".instr"}, {112'b0, n_out_instr}, {112'b0, exp_instr});
        check({name, ".ctrl"}, {112'b0, n_out_ctrl}, {112'b0, exp_ctrl});
    endtask

`ifdef PIPE_SKID_EN
    localparam logic SKID = 1'b1;
`else
    localparam logic SKID = 1'b0;
`endif

    initial begin
        rst         = 1'b1;
        w_in_valid  = 1'b0;
        w_in_instr  = '0;
        w_in_ctrl   = '0;
        w_in_data   = '0;
        w_out_ready = 1'b0;
        w_bubble    = 1'b0;
        w_flush     = 1'b0;

        // Reset with an instruction already offered.
        applyStimulus(1'b1, 16'hD2A4, 1'b1, 1'b0, 1'b0);
        checkReady("rst_ready", 1'b0);
        tick();
        checkOutput("rst_a", 1'b0, 16'h0800, 16'h0000);
        checkReady("rst_ready_b", 1'b0);
        tick();
        checkOutput("rst_b", 1'b0, 16'h0800, 16'h0000);
        check("rst_data", {64'b0, n_out_data}, 128'd0);

        rst = 1'b0;
        #1;
        checkReady("release_ready", 1'b1);
        tick();
        checkOutput("first", 1'b1, 16'hD2A4, 16'h7701);

        // Backpressure.
        applyStimulus(1'b1, 16'h1111, 1'b1, 1'b0, 1'b0);
        checkReady("bp_acc_ready", 1'b1);
        tick();
        checkOutput("bp_acc", 1'b1, 16'h1111, 16'hB4B4);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 16'h2222, 1'b0, 1'b0, 1'b0);
            checkReady("bp_stall_ready", SKID && (i == 0));
            tick();
            checkOutput("bp_hold", 1'b1, 16'h1111, 16'hB4B4);
        end
        applyStimulus(1'b1, 16'h2222, 1'b1, 1'b0, 1'b0);
        checkReady("bp_release_ready", !SKID);
        tick();
        checkOutput("bp_second", 1'b1, 16'h2222, 16'h8787);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("bp_empty", 1'b0, 16'h0800, 16'h0000);

        // Bubble.
        applyStimulus(1'b1, 16'h3333, 1'b1, 1'b1, 1'b0);
        checkReady("bubble_ready", 1'b0);
        tick();
        checkOutput("bubble_nop", 1'b0, 16'h0800, 16'h0000);
        applyStimulus(1'b1, 16'h3333, 1'b1, 1'b0, 1'b0);
        checkReady("post_bubble_ready", 1'b1);
        tick();
        checkOutput("post_bubble", 1'b1, 16'h3333, 16'h9696);

        // Flush while stalled with a pending entry.
        applyStimulus(1'b1, 16'h4444, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("fl_load", 1'b1, 16'h4444, 16'hE1E1);
        applyStimulus(1'b1, 16'h5555, 1'b0, 1'b0, 1'b0);
        checkReady("fl_pend_ready", SKID);
        tick();
        checkOutput("fl_stall", 1'b1, 16'h4444, 16'hE1E1);
        applyStimulus(1'b1, 16'h5555, 1'b0, 1'b0, 1'b1);
        checkReady("fl_ready", 1'b0);
        tick();
        checkOutput("fl_nop", 1'b0, 16'h0800, 16'h0000);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("fl_no_ghost_a", 1'b0, 16'h0800, 16'h0000);
        tick();
        checkOutput("fl_no_ghost_b", 1'b0, 16'h0800, 16'h0000);

        // Flush + bubble + offered input together.
        applyStimulus(1'b1, 16'h6666, 1'b1, 1'b1, 1'b1);
        checkReady("fb_ready", 1'b0);
        tick();
        checkOutput("fb_nop", 1'b0, 16'h0800, 16'h0000);
        applyStimulus(1'b1, 16'h6666, 1'b1, 1'b0, 1'b0);
        checkReady("fb_after_ready", 1'b1);
        tick();
        checkOutput("fb_after", 1'b1, 16'h6666, 16'hC3C3);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("fb_drain", 1'b0, 16'h0800, 16'h0000);

        // Randomized stream on the wide instance.
        wide_run = 1'b1;
        for (int i = 0; i < 400; i++) begin
            w_in_valid  = 1'($urandom_range(0, 1));
            w_in_instr  = $urandom;
            w_in_ctrl   = 24'($urandom);
            w_in_data   = {$urandom, $urandom, $urandom};
            w_out_ready = 1'($urandom_range(0, 3) != 0);
            tick();
        end
        w_in_valid  = 1'b0;
        w_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("wide_leftover", 128'(w_sent.size()), 128'd0);
        check("wide_traffic", {127'b0, (w_sent_cnt > 50)}, 128'd1);
        check("wide_count", 128'(w_recv_cnt), 128'(w_sent_cnt));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
